wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameters: BUF_DEPTH, default 2, number of deferred ALU-write entries; NREGS, default 32, architectural register count.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_valid  in  1  ALU result present this cycle.
REQ-005 alu_rd  in  reg_w  ALU destination register.
REQ-006 alu_result  in  word_t  ALU result data.
REQ-007 alu_ready  out  1  ALU result accepted this cycle.
REQ-008 ld_issue  in  1  load issued to memory.
REQ-009 ld_rd  in  reg_w  load destination register.
REQ-010 ld_ready  out  1  a load issue is accepted this cycle.
REQ-011 ld_done  in  1  load data returned this cycle.
REQ-012 ld_data  in  word_t  returned load data.
REQ-013 rs1, rs2  in  reg_w  source registers of the instruction in decode.
REQ-014 stall  out  1  decode must hold; combinational.
REQ-015 reg_write  out  1  register-file write enable, registered.
REQ-016 write_index  out  reg_w  register-file write address, registered.
REQ-017 write_data  out  word_t  register-file write data, registered.

Function
REQ-018 Two-state FSM: IDLE (no load outstanding), LD_WAIT (one load outstanding, tag = captured ld_rd).
REQ-019 IDLE: ld_ready=1; ld_issue -> capture ld_rd, go LD_WAIT; ld_issue with ld_rd=0 -> stay IDLE.
REQ-020 LD_WAIT: ld_ready=0; ld_issue ignored; ld_done -> go IDLE next cycle; ld_done in IDLE ignored.
REQ-021 Write priority per cycle: ld_done (tag valid) > oldest buffered ALU entry > incoming ALU result; at most one register-file write per cycle.
REQ-022 Write latency: selected write appears on reg_write/write_index/write_data exactly one cycle after selection.
REQ-023 Incoming ALU result written directly only when buffer is empty and no load write is selected; otherwise pushed into buffer.
REQ-024 alu_ready = 1 when buffer not full, or when buffer full and a buffered entry pops this cycle; alu_valid with alu_ready=0 is not consumed.
REQ-025 Writes to x0 never asserted: ALU result with alu_rd=0 is accepted and dropped (not buffered).
REQ-026 WAW: accepted ALU write whose alu_rd equals the outstanding load tag clears the tag valid bit; the later ld_done returns FSM to IDLE but produces no write.
REQ-027 stall = 1 when rs1 or rs2 (nonzero) matches the valid load tag or any valid buffer entry rd; reads of x0 never stall.
REQ-028 Simultaneous ld_done and buffer pop request: load writes, buffer holds; push and pop in same cycle keep occupancy unchanged.
REQ-029 Buffer is strict FIFO; entries for the same rd drain in acceptance order.

Reset
REQ-030 On rst high at a clock edge: FSM=IDLE, tag valid=0, buffer empty, reg_write=0, write_index=0, write_data=0; rst overrides all same-cycle inputs.
REQ-031 During reset cycle alu_ready=0, ld_ready=0; stall=0.
REQ-032 Reset mid-LD_WAIT discards the outstanding load; a subsequent ld_done while IDLE produces no write.

Structure
REQ-033 reg_w (5-bit) and word_t (32-bit) come from cpu_types_pkg; FSM state enum and BUF_DEPTH default are added there.
REQ-034 Deferred buffer is one sub-module, wb_skid_fifo, exposing push, pop, full, empty, head entry and per-entry rd/valid for hazard compare.

Verification
REQ-035 ALU alu_rd=5, alu_result=0x1234 in IDLE -> next cycle reg_write=1, write_index=5, write_data=0x1234.
REQ-036 ld_issue ld_rd=7; rs1=7 -> stall=1 until ld_done with 0xCAFE; next cycle write x7=0xCAFE; stall=0.
REQ-037 ld_done 0xAA (rd 3) with ALU rd 4 =0xBB same cycle -> cycle+1 writes x3=0xAA, cycle+2 writes x4=0xBB.
REQ-038 Three ALU results during three consecutive ld_done-blocked cycles, BUF_DEPTH=2 -> alu_ready=0 on third; all accepted writes later drain in order.
REQ-039 Load tag 9 outstanding, ALU write x9=0x11 -> x9=0x11 written; ld_done 0x22 -> no write, FSM IDLE.
REQ-040 rst during LD_WAIT then ld_done; and ALU rd=0 -> reg_write stays 0 throughout.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the writeback controller's FSM states and buffer defaults.
package cpu_types_pkg;
  localparam int XLEN          = 32;
  localparam int REG_W         = 5;
  localparam int BUF_DEPTH_DEF = 2;

  typedef logic [REG_W-1:0] reg_w;
  typedef logic [XLEN-1:0]  word_t;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } wb_state_e;
endpackage

// File: rtl/wb_skid_fifo.sv
// Strict-FIFO buffer of deferred ALU writes; exposes every slot's rd/valid for hazard compare.
// Caller must never push while full unless it pops in the same cycle.
module wb_skid_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [REG_W-1:0]       push_rd,
  input  logic [XLEN-1:0]        push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [REG_W-1:0]       head_rd,
  output logic [XLEN-1:0]        head_data,
  output logic [DEPTH*REG_W-1:0] ent_rd,
  output logic [DEPTH-1:0]       ent_vld
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_W-1:0] rd_mem_q  [DEPTH];
  logic [XLEN-1:0]  dat_mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pop clears before push sets, so a full-buffer push+pop keeps the reused slot valid.
  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        rd_mem_q[wr_ptr_q]  <= push_rd;
        dat_mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      vld_q <= vld_d;
    end
  end

  assign full      = &vld_q;
  assign empty     = ~|vld_q;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = dat_mem_q[rd_ptr_q];
  assign ent_vld   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_rd[i*REG_W +: REG_W] = rd_mem_q[i];
  end
endmodule

// File: rtl/wb_ctrl.sv
// Writeback arbiter: one outstanding load plus a small FIFO of deferred ALU writes, with decode hazard detection.
// Register-file write is registered (1 cycle after selection); ALU is backpressured via alu_ready when the buffer is full.
module wb_ctrl
  import cpu_types_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int NREGS     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_result,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_rd,
  output logic             ld_ready,
  input  logic             ld_done,
  input  logic [XLEN-1:0]  ld_data,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             stall,
  output logic             reg_write,
  output logic [REG_W-1:0] write_index,
  output logic [XLEN-1:0]  write_data
);
  wb_state_e        state_q;
  logic [REG_W-1:0] tag_q;
  logic             tag_vld_q;
  logic             reg_write_q, reg_write_d;
  logic [REG_W-1:0] write_index_q, write_index_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;

  logic                       buf_full, buf_empty, buf_push, buf_pop;
  logic [REG_W-1:0]           buf_head_rd;
  logic [XLEN-1:0]            buf_head_data;
  logic [BUF_DEPTH*REG_W-1:0] buf_ent_rd;
  logic [BUF_DEPTH-1:0]       buf_ent_vld;

  logic ld_wr, alu_acc, alu_live, direct_wr;
  logic rs1_hit, rs2_hit;

  // Registers outside the architected file behave like x0: never written, never tracked.
  function automatic logic is_arch(input logic [REG_W-1:0] r);
    return (r != '0) && (int'(r) < NREGS);
  endfunction

  assign ld_wr     = (state_q == LD_WAIT) && ld_done && tag_vld_q;
  assign buf_pop   = !ld_wr && !buf_empty;
  assign alu_ready = !rst && (!buf_full || buf_pop);
  assign alu_acc   = alu_valid && alu_ready;
  assign alu_live  = alu_acc && is_arch(alu_rd);
  assign direct_wr = alu_live && buf_empty && !ld_wr;
  assign buf_push  = alu_live && !direct_wr;
  assign ld_ready  = !rst && (state_q == IDLE);

  always_comb begin
    reg_write_d   = ld_wr || buf_pop || direct_wr;
    write_index_d = write_index_q;
    write_data_d  = write_data_q;
    if (ld_wr) begin
      write_index_d = tag_q;
      write_data_d  = ld_data;
    end else if (buf_pop) begin
      write_index_d = buf_head_rd;
      write_data_d  = buf_head_data;
    end else if (direct_wr) begin
      write_index_d = alu_rd;
      write_data_d  = alu_result;
    end
  end

  always_comb begin
    rs1_hit = tag_vld_q && (tag_q == rs1);
    rs2_hit = tag_vld_q && (tag_q == rs2);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (buf_ent_vld[i] && (buf_ent_rd[i*REG_W +: REG_W] == rs1)) rs1_hit = 1'b1;
      if (buf_ent_vld[i] && (buf_ent_rd[i*REG_W +: REG_W] == rs2)) rs2_hit = 1'b1;
    end
  end

  assign stall = !rst && ((is_arch(rs1) && rs1_hit) || (is_arch(rs2) && rs2_hit));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      tag_vld_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      case (state_q)
        IDLE: begin
          if (ld_issue && is_arch(ld_rd)) begin
            state_q   <= LD_WAIT;
            tag_q     <= ld_rd;
            tag_vld_q <= 1'b1;
          end
        end
        LD_WAIT: begin
          if (ld_done) begin
            state_q   <= IDLE;
            tag_vld_q <= 1'b0;
          end else if (alu_live && tag_vld_q && (alu_rd == tag_q)) begin
            // A younger ALU write to the load's rd makes the load's data dead.
            tag_vld_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_write   = reg_write_q;
  assign write_index = write_index_q;
  assign write_data  = write_data_q;

  wb_skid_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_rd   (alu_rd),
    .push_data (alu_result),
    .pop       (buf_pop),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_rd   (buf_head_rd),
    .head_data (buf_head_data),
    .ent_rd    (buf_ent_rd),
    .ent_vld   (buf_ent_vld)
  );
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios with literal expectations, then randomized traffic against a queue model.
module tb_wb_ctrl;
  import cpu_types_pkg::*;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, alu_valid, ld_issue, ld_done;
  logic [4:0]  alu_rd, ld_rd, rs1, rs2;
  logic [31:0] alu_result, ld_data;
  logic        alu_ready, ld_ready, stall, reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;

  wb_ctrl #(.BUF_DEPTH(DEPTH), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_wr(input string name, input logic [4:0] idx, input logic [31:0] dat);
    chk({name, "_we"}, reg_write, 1);
    chk({name, "_idx"}, write_index, idx);
    chk({name, "_dat"}, write_data, dat);
  endtask

  // Reference model: one pending load record plus a queue of deferred ALU writes.
  bit          m_on = 0;
  bit          m_busy, m_live;
  logic [4:0]  m_tag;
  logic [4:0]  q_rd[$];
  logic [31:0] q_dat[$];
  bit          e_we;
  logic [4:0]  e_idx;
  logic [31:0] e_dat;

  function automatic bit m_ldwr();
    return m_busy && m_live && ld_done;
  endfunction
  function automatic bit m_pop();
    return !m_ldwr() && (q_rd.size() > 0);
  endfunction
  function automatic bit m_aready();
    return !rst && ((q_rd.size() < DEPTH) || m_pop());
  endfunction
  function automatic bit m_hz(input logic [4:0] r);
    if (r == 0) return 0;
    if (m_busy && m_live && m_tag == r) return 1;
    foreach (q_rd[i]) if (q_rd[i] == r) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit lw, pp, live, had;
    if (rst) begin
      m_on = 1; m_busy = 0; m_live = 0;
      q_rd.delete(); q_dat.delete();
      e_we = 0; e_idx = 0; e_dat = 0;
    end else begin
      lw   = m_ldwr();
      pp   = m_pop();
      live = alu_valid && m_aready() && (alu_rd != 0);
      had  = q_rd.size() > 0;
      e_we = 0;
      if (lw) begin
        e_we = 1; e_idx = m_tag; e_dat = ld_data;
      end else if (pp) begin
        e_we = 1; e_idx = q_rd.pop_front(); e_dat = q_dat.pop_front();
      end else if (live) begin
        e_we = 1; e_idx = alu_rd; e_dat = alu_result;
      end
      if (live && (lw || had)) begin
        q_rd.push_back(alu_rd);
        q_dat.push_back(alu_result);
      end
      if (m_busy) begin
        if (ld_done) begin
          m_busy = 0; m_live = 0;
        end else if (live && alu_rd == m_tag) begin
          m_live = 0;
        end
      end else if (ld_issue && ld_rd != 0) begin
        m_busy = 1; m_live = 1; m_tag = ld_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_reg_write", reg_write, e_we);
      if (e_we) begin
        chk("m_write_index", write_index, e_idx);
        chk("m_write_data", write_data, e_dat);
      end
      chk("m_alu_ready", alu_ready, m_aready());
      chk("m_ld_ready", ld_ready, !rst && !m_busy);
      chk("m_stall", stall, !rst && (m_hz(rs1) || m_hz(rs2)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_rd = 0; ld_done = 0; ld_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_result = d;
  endtask

  initial begin
    idle();
    rst = 1;
    alu(5'd3, 32'h77); ld_issue = 1; ld_rd = 5'd4; rs1 = 5'd4;
    tick(); tick();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_index", write_index, 0);
    chk("rst_write_data", write_data, 0);
    idle(); rst = 0;
    tick();

    // Plain ALU write, idle controller.
    alu(5'd5, 32'h1234); tick(); idle();
    chk_wr("t035", 5'd5, 32'h1234);

    // Load hazard and return.
    ld_issue = 1; ld_rd = 5'd7; #1 chk("t036_ld_ready", ld_ready, 1);
    tick(); idle();
    rs1 = 5'd7; #1 chk("t036_stall_a", stall, 1); chk("t036_ld_busy", ld_ready, 0);
    tick();
    ld_done = 1; ld_data = 32'hCAFE; #1 chk("t036_stall_b", stall, 1);
    tick(); idle();
    chk_wr("t036", 5'd7, 32'hCAFE);
    rs1 = 5'd7; #1 chk("t036_stall_clr", stall, 0);
    tick(); idle();

    // Load beats a same-cycle ALU result.
    ld_issue = 1; ld_rd = 5'd3; tick(); idle(); tick();
    ld_done = 1; ld_data = 32'hAA; alu(5'd4, 32'hBB); tick(); idle();
    chk_wr("t037_ld", 5'd3, 32'hAA);
    rs2 = 5'd4; #1 chk("t037_stall_buf", stall, 1);
    tick(); idle();
    chk_wr("t037_alu", 5'd4, 32'hBB);

    // Fill the buffer by interleaving load returns with ALU traffic.
    ld_issue = 1; ld_rd = 5'd10; tick(); idle();
    ld_done = 1; ld_data = 32'h50; alu(5'd11, 32'h101); tick(); idle();
    chk_wr("t038_a", 5'd10, 32'h50);
    ld_issue = 1; ld_rd = 5'd12; alu(5'd13, 32'h102); tick(); idle();
    chk_wr("t038_b", 5'd11, 32'h101);
    ld_done = 1; ld_data = 32'h52; alu(5'd14, 32'h103); tick(); idle();
    ld_issue = 1; ld_rd = 5'd15; alu(5'd16, 32'h104);
    #1 chk("t038_ready_pop", alu_ready, 1);
    tick(); idle();
    chk_wr("t038_d", 5'd13, 32'h102);
    ld_done = 1; ld_data = 32'h55; alu(5'd17, 32'h105);
    #1 chk("t038_ready_full", alu_ready, 0);
    tick(); idle();
    chk_wr("t038_e", 5'd15, 32'h55);
    alu(5'd17, 32'h105); tick(); idle();
    chk_wr("t038_f", 5'd14, 32'h103);
    tick();
    chk_wr("t038_g", 5'd16, 32'h104);
    tick();
    chk_wr("t038_h", 5'd17, 32'h105);
    tick();
    chk("t038_drained", reg_write, 0);

    // WAW: ALU overwrites the outstanding load's destination.
    ld_issue = 1; ld_rd = 5'd9; tick(); idle();
    alu(5'd9, 32'h11); tick(); idle();
    chk_wr("t039_alu", 5'd9, 32'h11);
    rs1 = 5'd9; #1 chk("t039_stall", stall, 0);
    ld_done = 1; ld_data = 32'h22; tick(); idle();
    chk("t039_no_wr", reg_write, 0);
    #1 chk("t039_idle", ld_ready, 1);

    // Reset discards the load; x0 writes dropped.
    ld_issue = 1; ld_rd = 5'd20; tick(); idle();
    rst = 1; tick(); rst = 0;
    ld_done = 1; ld_data = 32'h33; tick(); idle();
    chk("t040_no_ld", reg_write, 0);
    alu(5'd0, 32'hDEAD); #1 chk("t040_ready", alu_ready, 1);
    tick(); idle();
    chk("t040_x0_a", reg_write, 0);
    tick();
    chk("t040_x0_b", reg_write, 0);

    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      alu_valid  = ($urandom_range(0, 2) != 0);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_result = $urandom;
      ld_issue   = ($urandom_range(0, 3) == 0);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_done    = ($urandom_range(0, 2) == 0);
      ld_data    = $urandom;
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 0; idle();
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
